pong_game_ctrl: RTL and testbench



---
 rtl/pong_game_ctrl.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_pong_game_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pong_game_ctrl.sv
// ---------------------------------------------------------------------------
// pong_game_ctrl
//
// Frame-rate game sequencer for the Pong display. Owns the ball position and
// direction, both player scores and the IDLE/SERVE/PLAY/POINT/OVER state
// machine. The ball advances once per video frame (frame_tick). Wall and
// paddle collisions are resolved against the paddle tops supplied by the
// paddle input logic.
//
// Ports
//   CLK_50       in   1   50 MHz system clock
//   reset        in   1   synchronous, active-high reset
//   frame_tick   in   1   one-cycle pulse at the start of vertical blank
//   start        in   1   start/restart button level (rising edge used)
//   p1_y         in  10   left paddle top y
//   p2_y         in  10   right paddle top y
//   ball_x       out 10   ball left x
//   ball_y       out 10   ball top y
//   score_p1     out  4   left player score
//   score_p2     out  4   right player score
//   state        out  3   IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4
//   point_pulse  out  1   one-cycle pulse in the cycle after a point is scored
//   game_over    out  1   high while in OVER
//   winner       out  1   0 = P1 won, 1 = P2 won (valid while game_over)
//
// Every output is driven directly by a flop.
// ---------------------------------------------------------------------------
module pong_game_ctrl #(
  parameter int SPEED        = 2,
  parameter int BALL_SIZE    = 5,
  parameter int PADDLE_W     = 10,
  parameter int PADDLE_H     = 120,
  parameter int P1_X         = 20,
  parameter int P2_X         = 610,
  parameter int WALL_TOP     = 2,
  parameter int WALL_BOT     = 473,
  parameter int WALL_L       = 2,
  parameter int WALL_R       = 633,
  parameter int CENTER_X     = 318,
  parameter int CENTER_Y     = 238,
  parameter int SERVE_FRAMES = 60,
  parameter int WIN_SCORE    = 7
) (
  input  logic       CLK_50,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       start,
  input  logic [9:0] p1_y,
  input  logic [9:0] p2_y,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [3:0] score_p1,
  output logic [3:0] score_p2,
  output logic [2:0] state,
  output logic       point_pulse,
  output logic       game_over,
  output logic       winner
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    POINT = 3'd3,
    OVER  = 3'd4
  } state_t;

  // Serve counter is wide enough to hold SERVE_FRAMES (and never 0 bits wide).
  localparam int CNT_W = $clog2(SERVE_FRAMES + 2);
  localparam logic [CNT_W-1:0] SERVE_LOAD = CNT_W'(SERVE_FRAMES);

  // 11-bit comparison constants: one spare bit so sums and differences
  // of 10-bit coordinates never wrap.
  localparam logic [10:0] K_SPEED   = 11'(SPEED);
  localparam logic [10:0] K_BALL    = 11'(BALL_SIZE);
  localparam logic [10:0] K_PAD_H   = 11'(PADDLE_H);
  localparam logic [10:0] K_TOP_LIM = 11'(WALL_TOP + SPEED);
  localparam logic [10:0] K_BOT     = 11'(WALL_BOT);
  localparam logic [10:0] K_P1_EDGE = 11'(P1_X + PADDLE_W);
  localparam logic [10:0] K_P2_EDGE = 11'(P2_X - BALL_SIZE);
  localparam logic [10:0] K_MISS_L  = 11'(WALL_L + SPEED);
  localparam logic [10:0] K_WALL_R  = 11'(WALL_R);

  // 10-bit coordinate values loaded into the ball registers.
  localparam logic [9:0] V_SPEED   = 10'(SPEED);
  localparam logic [9:0] V_TOP     = 10'(WALL_TOP);
  localparam logic [9:0] V_BOT     = 10'(WALL_BOT);
  localparam logic [9:0] V_P1_EDGE = 10'(P1_X + PADDLE_W);
  localparam logic [9:0] V_P2_EDGE = 10'(P2_X - BALL_SIZE);
  localparam logic [9:0] V_CX      = 10'(CENTER_X);
  localparam logic [9:0] V_CY      = 10'(CENTER_Y);
  localparam logic [3:0] V_WIN     = 4'(WIN_SCORE);

  state_t           st;
  logic             dx;          // 1 = moving right, 0 = moving left
  logic             dy;          // 1 = moving down,  0 = moving up
  logic [CNT_W-1:0] serve_cnt;
  logic             start_q;
  logic             scored_p2;   // who scored the point being processed in POINT

  logic start_rise;
  assign start_rise = start & ~start_q;

  assign state = st;

  // -------------------------------------------------------------------------
  // Next ball position / direction for one PLAY frame.
  // -------------------------------------------------------------------------
  logic [10:0] bx, by, p1y, p2y;
  logic [10:0] x_inc, x_dec, y_inc;
  logic [9:0]  y_dec;
  logic        ovl_1, ovl_2;
  logic        hit_l, hit_r, miss_l, miss_r;
  logic [9:0]  nx, ny;
  logic        ndx, ndy;

  always_comb begin
    // NOTE: every signal gets a default at the top so no path leaves it
    // unassigned; a missing default would infer a latch.
    bx    = {1'b0, ball_x};
    by    = {1'b0, ball_y};
    p1y   = {1'b0, p1_y};
    p2y   = {1'b0, p2_y};
    x_inc = bx + K_SPEED;
    x_dec = bx - K_SPEED;
    y_inc = by + K_SPEED;
    y_dec = ball_y - V_SPEED;
    nx    = ball_x;
    ny    = ball_y;
    ndx   = dx;
    ndy   = dy;

    // Vertical overlap uses the ball's current (pre-move) y.
    ovl_1 = ((by + K_BALL) > p1y) && (by < (p1y + K_PAD_H));
    ovl_2 = ((by + K_BALL) > p2y) && (by < (p2y + K_PAD_H));

    // Paddle hits catch the ball when this frame's step would reach or cross
    // the paddle face; the ball is then parked exactly on that face.
    hit_l = !dx && (bx >= K_P1_EDGE) && (x_dec <= K_P1_EDGE) && ovl_1;
    hit_r =  dx && (bx <= K_P2_EDGE) && (x_inc >= K_P2_EDGE) && ovl_2;

    miss_l = !dx && (bx < K_MISS_L);
    miss_r =  dx && (x_inc > K_WALL_R);

    // Vertical: clamp to the wall and reflect.
    if (!dy) begin
      if (by < K_TOP_LIM) begin
        ny  = V_TOP;
        ndy = 1'b1;
      end else begin
        ny  = y_dec;
      end
    end else begin
      if (y_inc > K_BOT) begin
        ny  = V_BOT;
        ndy = 1'b0;
      end else begin
        ny  = y_inc[9:0];
      end
    end

    // Horizontal: paddle faces take precedence over free movement.
    if (hit_l) begin
      nx  = V_P1_EDGE;
      ndx = 1'b1;
    end else if (hit_r) begin
      nx  = V_P2_EDGE;
      ndx = 1'b0;
    end else if (dx) begin
      nx  = x_inc[9:0];
    end else begin
      nx  = x_dec[9:0];
    end
  end

  // Score of whoever took the last point has reached the winning total.
  logic win_reached;
  assign win_reached = scored_p2 ? (score_p2 == V_WIN) : (score_p1 == V_WIN);

  // -------------------------------------------------------------------------
  // Game state machine and all registered outputs.
  // -------------------------------------------------------------------------
  // NOTE: state is updated with non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK_50) begin
    if (reset) begin
      st          <= IDLE;
      ball_x      <= V_CX;
      ball_y      <= V_CY;
      dx          <= 1'b1;
      dy          <= 1'b0;
      score_p1    <= 4'd0;
      score_p2    <= 4'd0;
      serve_cnt   <= '0;
      start_q     <= 1'b0;
      scored_p2   <= 1'b0;
      point_pulse <= 1'b0;
      game_over   <= 1'b0;
      winner      <= 1'b0;
    end else begin
      start_q     <= start;
      point_pulse <= 1'b0;

      case (st)
        IDLE: begin
          // frame_tick has no effect here; only the button starts a game.
          if (start_rise) begin
            st        <= SERVE;
            serve_cnt <= SERVE_LOAD;
          end
        end

        SERVE: begin
          ball_x <= V_CX;
          ball_y <= V_CY;
          dy     <= 1'b0;
          if (frame_tick) begin
            serve_cnt <= serve_cnt - 1'b1;
            // <= 1 rather than == 1 so a zero-frame serve cannot stall.
            if (serve_cnt <= CNT_W'(1)) begin
              st <= PLAY;
            end
          end
        end

        PLAY: begin
          if (frame_tick) begin
            // A miss freezes the ball where it is; POINT recentres it.
            if (miss_l) begin
              score_p2    <= score_p2 + 4'd1;
              scored_p2   <= 1'b1;
              point_pulse <= 1'b1;
              st          <= POINT;
            end else if (miss_r) begin
              score_p1    <= score_p1 + 4'd1;
              scored_p2   <= 1'b0;
              point_pulse <= 1'b1;
              st          <= POINT;
            end else begin
              ball_x <= nx;
              ball_y <= ny;
              dx     <= ndx;
              dy     <= ndy;
            end
          end
        end

        POINT: begin
          ball_x <= V_CX;
          ball_y <= V_CY;
          // Next serve heads toward the player who conceded: P1 scoring
          // means P2 (right side) conceded, so serve right.
          dx     <= ~scored_p2;
          if (win_reached) begin
            st        <= OVER;
            game_over <= 1'b1;
            winner    <= scored_p2;
          end else begin
            st        <= SERVE;
            serve_cnt <= SERVE_LOAD;
          end
        end

        OVER: begin
          ball_x <= V_CX;
          ball_y <= V_CY;
          if (start_rise) begin
            score_p1  <= 4'd0;
            score_p2  <= 4'd0;
            game_over <= 1'b0;
            dx        <= 1'b1;
            dy        <= 1'b0;
            serve_cnt <= SERVE_LOAD;
            st        <= SERVE;
          end
        end

        default: begin
          st <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pong_game_ctrl
//
// Directed bench for pong_game_ctrl built with a three-frame serve. A table
// of frame-count / expected-position records walks one long rally through
// the top wall, the right paddle, the bottom wall and the left paddle;
// hand-written sequences cover reset mid-play, the start/tick collision,
// repeated P1 points up to game over, restart, and a P2 point.
// ---------------------------------------------------------------------------
module tb_pong_game_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_tick;
  logic       start;
  logic [9:0] p1_y;
  logic [9:0] p2_y;
  logic [9:0] ball_x;
  logic [9:0] ball_y;
  logic [3:0] score_p1;
  logic [3:0] score_p2;
  logic [2:0] state;
  logic       point_pulse;
  logic       game_over;
  logic       winner;

  always #10 clk = ~clk;

  pong_game_ctrl #(.SERVE_FRAMES(3)) dut (
    .CLK_50      (clk),
    .reset       (reset),
    .frame_tick  (frame_tick),
    .start       (start),
    .p1_y        (p1_y),
    .p2_y        (p2_y),
    .ball_x      (ball_x),
    .ball_y      (ball_y),
    .score_p1    (score_p1),
    .score_p2    (score_p2),
    .state       (state),
    .point_pulse (point_pulse),
    .game_over   (game_over),
    .winner      (winner)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock with no tick; outputs are sampled 1 time unit after the edge.
  task automatic idle();
    @(posedge clk); #1;
  endtask

  // n frames: each is one quiet cycle followed by a one-cycle tick.
  // Returns just after the edge that sampled the last tick.
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      frame_tick = 1'b1;
      @(posedge clk); #1;
      frame_tick = 1'b0;
    end
  endtask

  task automatic check_ball(input string tag, input int ex, input int ey);
    check({tag, ".ball_x"}, 32'(ball_x), 32'(ex));
    check({tag, ".ball_y"}, 32'(ball_y), 32'(ey));
  endtask

  typedef struct {
    string      name;
    int         n_ticks;
    logic [9:0] p1;
    logic [9:0] p2;
    int         ex;
    int         ey;
  } vec_t;

  vec_t vecs[13];

  // Bound on the whole run so a stuck design still reaches a verdict.
  initial begin
    #(20 * 20000);
    $display("FAIL watchdog: run did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Rally from centre with dx=+, dy=-; k = PLAY frames since serve.
    vecs[0]  = '{"first_step",   1,   10'd250, 10'd0, 320, 236}; // k=1
    vecs[1]  = '{"near_top",     117, 10'd250, 10'd0, 554, 2};   // k=118
    vecs[2]  = '{"top_clamp",    1,   10'd250, 10'd0, 556, 2};   // k=119 dy->+
    vecs[3]  = '{"top_reflect",  1,   10'd250, 10'd0, 558, 4};   // k=120
    vecs[4]  = '{"before_rpad",  23,  10'd250, 10'd0, 604, 50};  // k=143
    vecs[5]  = '{"rpad_hit",     1,   10'd250, 10'd0, 605, 52};  // k=144 dx->-
    vecs[6]  = '{"rpad_leave",   1,   10'd250, 10'd0, 603, 54};  // k=145
    vecs[7]  = '{"near_bot",     209, 10'd250, 10'd0, 185, 472}; // k=354
    vecs[8]  = '{"bot_clamp",    1,   10'd250, 10'd0, 183, 473}; // k=355 dy->-
    vecs[9]  = '{"bot_reflect",  1,   10'd250, 10'd0, 181, 471}; // k=356
    vecs[10] = '{"before_lpad",  75,  10'd250, 10'd0, 31,  321}; // k=431
    vecs[11] = '{"lpad_hit",     1,   10'd250, 10'd0, 30,  319}; // k=432 dx->+
    vecs[12] = '{"lpad_leave",   1,   10'd250, 10'd0, 32,  317}; // k=433

    reset      = 1'b1;
    frame_tick = 1'b0;
    start      = 1'b0;
    p1_y       = 10'd250;
    p2_y       = 10'd0;

    // ---- reset values ----
    idle();
    idle();
    check("rst.state", 32'(state), 32'd0);
    check_ball("rst", 318, 238);
    check("rst.score_p1", 32'(score_p1), 32'd0);
    check("rst.score_p2", 32'(score_p2), 32'd0);
    check("rst.point_pulse", 32'(point_pulse), 32'd0);
    check("rst.game_over", 32'(game_over), 32'd0);
    check("rst.winner", 32'(winner), 32'd0);
    reset = 1'b0;

    // ---- ticks ignored in IDLE ----
    ticks(1);
    check("idle_tick.state", 32'(state), 32'd0);
    check_ball("idle_tick", 318, 238);

    // ---- start rise together with a tick: tick is not counted ----
    start      = 1'b1;
    frame_tick = 1'b1;
    idle();
    frame_tick = 1'b0;
    start      = 1'b0;
    check("start_tick.state", 32'(state), 32'd1);
    ticks(2);
    check("serve2.state", 32'(state), 32'd1);
    ticks(1);
    check("serve3.state", 32'(state), 32'd2);
    check_ball("serve3", 318, 238);

    // ---- table-driven rally ----
    for (int v = 0; v < 13; v++) begin
      p1_y = vecs[v].p1;
      p2_y = vecs[v].p2;
      ticks(vecs[v].n_ticks);
      check_ball(vecs[v].name, vecs[v].ex, vecs[v].ey);
      check({vecs[v].name, ".state"}, 32'(state), 32'd2);
      check({vecs[v].name, ".point_pulse"}, 32'(point_pulse), 32'd0);
    end

    // ---- reset mid-play, with a tick present ----
    reset      = 1'b1;
    frame_tick = 1'b1;
    idle();
    frame_tick = 1'b0;
    check("mid_rst.state", 32'(state), 32'd0);
    check_ball("mid_rst", 318, 238);
    check("mid_rst.score_p1", 32'(score_p1), 32'd0);
    check("mid_rst.point_pulse", 32'(point_pulse), 32'd0);
    check("mid_rst.game_over", 32'(game_over), 32'd0);
    reset = 1'b0;

    // ---- right-side miss: P1 scores ----
    p1_y  = 10'd250;
    p2_y  = 10'd300;
    start = 1'b1;
    idle();
    start = 1'b0;
    check("miss.serve_state", 32'(state), 32'd1);
    ticks(3);
    check("miss.play_state", 32'(state), 32'd2);
    ticks(157);
    check_ball("miss.k157", 632, 78);
    ticks(1);
    check("miss.point_state", 32'(state), 32'd3);
    check("miss.point_pulse", 32'(point_pulse), 32'd1);
    check("miss.score_p1", 32'(score_p1), 32'd1);
    check("miss.score_p2", 32'(score_p2), 32'd0);
    idle();
    check("miss.after_state", 32'(state), 32'd1);
    check("miss.pulse_drop", 32'(point_pulse), 32'd0);
    check_ball("miss.recentre", 318, 238);
    // Serve heads toward P2 (conceded) and dy is forced up.
    ticks(4);
    check_ball("miss.reserve", 320, 236);

    // ---- repeat the same rally until P1 reaches 7 ----
    for (int p = 2; p <= 7; p++) begin
      ticks(157);
      check($sformatf("pt%0d.state", p), 32'(state), 32'd3);
      check($sformatf("pt%0d.score_p1", p), 32'(score_p1), 32'(p));
      check($sformatf("pt%0d.point_pulse", p), 32'(point_pulse), 32'd1);
      idle();
      if (p < 7) begin
        check($sformatf("pt%0d.serve", p), 32'(state), 32'd1);
        ticks(4);
      end else begin
        check("over.state", 32'(state), 32'd4);
        check("over.game_over", 32'(game_over), 32'd1);
        check("over.winner", 32'(winner), 32'd0);
        check_ball("over", 318, 238);
      end
    end

    ticks(2);
    check("over_tick.state", 32'(state), 32'd4);

    // ---- restart from OVER; holding start does not restart again ----
    start = 1'b1;
    idle();
    check("restart.state", 32'(state), 32'd1);
    check("restart.score_p1", 32'(score_p1), 32'd0);
    check("restart.game_over", 32'(game_over), 32'd0);
    idle();
    idle();
    check("held.state", 32'(state), 32'd1);
    ticks(3);
    check("held.play", 32'(state), 32'd2);
    start = 1'b0;

    // ---- left-side miss: P2 scores ----
    p1_y = 10'd0;
    p2_y = 10'd0;
    ticks(445);
    check_ball("lmiss.k445", 3, 293);
    ticks(1);
    check("lmiss.state", 32'(state), 32'd3);
    check("lmiss.score_p2", 32'(score_p2), 32'd1);
    check("lmiss.score_p1", 32'(score_p1), 32'd0);
    check("lmiss.point_pulse", 32'(point_pulse), 32'd1);
    idle();
    check("lmiss.serve", 32'(state), 32'd1);
    // Serve heads toward P1 (conceded).
    ticks(4);
    check_ball("lmiss.reserve", 316, 236);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
